// File: rtl/command_dispatch_inex_if.sv
// Command/register-bus/response signal bundle for command_dispatch_inex.
// The slave modport is the dispatcher's view; master is the driver side.
interface command_dispatch_inex_if;
  logic [65:0] iv_command;
  logic        i_command_wr;
  logic [29:0] ov_addr;
  logic [31:0] ov_wdata;
  logic        o_wr;
  logic        o_rd;
  logic [31:0] iv_rdata;
  logic        i_rd_ack;
  logic [65:0] ov_resp;
  logic        o_resp_wr;
  logic [15:0] ov_drop_cnt;
  logic        o_busy;

  modport slave (
    input  iv_command, i_command_wr, iv_rdata, i_rd_ack,
    output ov_addr, ov_wdata, o_wr, o_rd, ov_resp, o_resp_wr, ov_drop_cnt, o_busy
  );

  modport master (
    output iv_command, i_command_wr, iv_rdata, i_rd_ack,
    input  ov_addr, ov_wdata, o_wr, o_rd, ov_resp, o_resp_wr, ov_drop_cnt, o_busy
  );
endinterface

// File: rtl/command_dispatch_inex.sv
// Buffers tagged commands in a FIFO and executes each as one register-bus access.
// Define WRITE_ACK_EN to emit a tagged acknowledge response after every write.
module command_dispatch_inex #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned FIFO_AW     = 3,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  command_dispatch_inex_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StDecode, StWait, StResp} state_e;

  localparam logic [1:0] TypeWr   = 2'b01;
  localparam logic [1:0] TypeRd   = 2'b10;
  localparam logic [1:0] TypeResp = 2'b11;
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT_CYC - 1);

  logic [65:0]      fifo_q [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic             fifo_empty, fifo_full, pop, push, fifo_drop;

  state_e      state_q;
  logic [65:0] hold_q;
  logic [7:0]  tmo_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q, rd_q, resp_wr_q;
  logic [65:0] resp_q;
  logic [15:0] drop_q, drop_d;
  logic        fsm_drop;
  logic [16:0] drop_sum;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop        = (state_q == StIdle) && !fifo_empty;
  assign push       = bus_io.i_command_wr && (!fifo_full || pop);
  assign fifo_drop  = bus_io.i_command_wr && !push;

  always_comb begin
    fsm_drop = 1'b0;
    if (state_q == StDecode) begin
      fsm_drop = (hold_q[65:64] != TypeWr) && (hold_q[65:64] != TypeRd);
    end else if (state_q == StWait) begin
      fsm_drop = !bus_io.i_rd_ack && (tmo_q == TmoLast);
    end
  end

  // A FIFO overflow and an FSM drop can land in the same cycle.
  always_comb begin
    drop_sum = {1'b0, drop_q} + {16'd0, fifo_drop} + {16'd0, fsm_drop};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_q[wptr_q[FIFO_AW-1:0]] <= bus_io.iv_command;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      rptr_q    <= '0;
      hold_q    <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      resp_wr_q <= 1'b0;
      resp_q    <= '0;
      drop_q    <= '0;
    end else begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      resp_wr_q <= 1'b0;
      resp_q    <= '0;
      drop_q    <= drop_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            hold_q  <= fifo_q[rptr_q[FIFO_AW-1:0]];
            rptr_q  <= rptr_q + 1'b1;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (hold_q[65:64] == TypeWr) begin
            addr_q  <= hold_q[61:32];
            wdata_q <= hold_q[31:0];
            wr_q    <= 1'b1;
`ifdef WRITE_ACK_EN
            state_q <= StResp;
`else
            state_q <= StIdle;
`endif
          end else if (hold_q[65:64] == TypeRd) begin
            addr_q  <= hold_q[61:32];
            rd_q    <= 1'b1;
            tmo_q   <= '0;
            state_q <= StWait;
          end else begin
            state_q <= StIdle;
          end
        end
        StWait: begin
          // Ack is checked first so it wins over a coincident timeout.
          if (bus_io.i_rd_ack) begin
            hold_q[31:0] <= bus_io.iv_rdata;
            state_q      <= StResp;
          end else if (tmo_q == TmoLast) begin
            hold_q[31:0] <= 32'hDEAD_BEEF;
            state_q      <= StResp;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        StResp: begin
          resp_q    <= {TypeResp, hold_q[63:0]};
          resp_wr_q <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.ov_addr     = addr_q;
  assign bus_io.ov_wdata    = wdata_q;
  assign bus_io.o_wr        = wr_q;
  assign bus_io.o_rd        = rd_q;
  assign bus_io.ov_resp     = resp_q;
  assign bus_io.o_resp_wr   = resp_wr_q;
  assign bus_io.ov_drop_cnt = drop_q;
  assign bus_io.o_busy      = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_command_dispatch_inex.sv
// Directed testbench for command_dispatch_inex: writes, reads, timeout, overflow,
// illegal types and reset during an outstanding read.
module tb_command_dispatch_inex;

  logic clk;
  logic rst_n;

  command_dispatch_inex_if bus ();

  command_dispatch_inex #(
    .FIFO_DEPTH (8),
    .FIFO_AW    (3),
    .TIMEOUT_CYC(255)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus_io (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [65:0] cmd);
    bus.iv_command   = cmd;
    bus.i_command_wr = 1'b1;
    cyc();
    bus.i_command_wr = 1'b0;
    bus.iv_command   = '0;
  endtask

  function automatic logic [65:0] mk(input logic [1:0] ty, input logic [1:0] tag,
                                     input logic [29:0] a, input logic [31:0] d);
    return {ty, tag, a, d};
  endfunction

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (bus.o_rd) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check_val({pfx, "_strobes"}, 66'({bus.o_wr, bus.o_rd, bus.o_resp_wr}), 66'd0);
    check_val({pfx, "_resp"}, bus.ov_resp, 66'd0);
    check_val({pfx, "_addr"}, 66'(bus.ov_addr), 66'd0);
    check_val({pfx, "_wdata"}, 66'(bus.ov_wdata), 66'd0);
    check_val({pfx, "_drop"}, 66'(bus.ov_drop_cnt), 66'd0);
    check_val({pfx, "_busy"}, 66'(bus.o_busy), 66'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    int k;

    rst_n            = 1'b0;
    bus.iv_command   = '0;
    bus.i_command_wr = 1'b0;
    bus.iv_rdata     = '0;
    bus.i_rd_ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    cyc();

    // Write: strobe two cycles after the push, no response.
    push(mk(2'b01, 2'b10, 30'h100, 32'h1234_5678));
    cyc();
    check_val("wr_early", 66'(bus.o_wr), 66'd0);
    cyc();
    check_val("wr_strobe", 66'(bus.o_wr), 66'd1);
    check_val("wr_addr", 66'(bus.ov_addr), 66'h100);
    check_val("wr_wdata", 66'(bus.ov_wdata), 66'h1234_5678);
    check_val("wr_noresp", 66'(bus.o_resp_wr), 66'd0);
    cyc();
    check_val("wr_pulse_end", 66'({bus.o_wr, bus.o_resp_wr}), 66'd0);
    check_val("wr_addr_hold", 66'(bus.ov_addr), 66'h100);

    // Read acked three cycles after the strobe.
    push(mk(2'b10, 2'b11, 30'h4, 32'h0));
    cyc();
    cyc();
    check_val("rd_strobe", 66'(bus.o_rd), 66'd1);
    check_val("rd_addr", 66'(bus.ov_addr), 66'h4);
    cyc();
    check_val("rd_pulse_end", 66'(bus.o_rd), 66'd0);
    cyc();
    cyc();
    bus.i_rd_ack = 1'b1;
    bus.iv_rdata = 32'hCAFE_0001;
    cyc();
    bus.i_rd_ack = 1'b0;
    bus.iv_rdata = '0;
    check_val("rd_resp_early", 66'(bus.o_resp_wr), 66'd0);
    cyc();
    check_val("rd_resp_wr", 66'(bus.o_resp_wr), 66'd1);
    check_val("rd_resp", bus.ov_resp, {2'b11, 2'b11, 30'h4, 32'hCAFE_0001});
    cyc();
    check_val("rd_resp_end", 66'(bus.o_resp_wr), 66'd0);
    check_val("rd_resp_zero", bus.ov_resp, 66'd0);

    // Read with no ack times out after 255 wait cycles.
    push(mk(2'b10, 2'b01, 30'h8, 32'h0));
    cyc();
    cyc();
    check_val("tmo_rd", 66'(bus.o_rd), 66'd1);
    k    = 0;
    seen = 1'b0;
    while (k < 400 && !seen) begin
      cyc();
      k++;
      if (bus.o_resp_wr) seen = 1'b1;
    end
    check_val("tmo_seen", 66'(seen), 66'd1);
    check_val("tmo_latency", 66'(k), 66'd256);
    check_val("tmo_resp", bus.ov_resp, {2'b11, 2'b01, 30'h8, 32'hDEAD_BEEF});
    check_val("tmo_drop", 66'(bus.ov_drop_cnt), 66'd1);
    bus.i_rd_ack = 1'b1;
    bus.iv_rdata = 32'h1111_1111;
    cyc();
    bus.i_rd_ack = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      cyc();
      seen |= bus.o_resp_wr | bus.o_rd;
    end
    check_val("late_ack_ignored", 66'(seen), 66'd0);
    check_val("late_ack_idle", 66'(bus.o_busy), 66'd0);

    // Ten back-to-back reads: one in flight, eight queued, one dropped.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) push(mk(2'b10, 2'(i), 30'(32'h40 + i), 32'h0));
    check_val("ovf_drop", 66'(bus.ov_drop_cnt), 66'd1);
    check_val("ovf_busy", 66'(bus.o_busy), 66'd1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        wait_rd(ok);
        check_val($sformatf("ovf_rd%0d_seen", i), 66'(ok), 66'd1);
      end
      check_val($sformatf("ovf_rd%0d_addr", i), 66'(bus.ov_addr), 66'(32'h40 + i));
      cyc();
      cyc();
      bus.i_rd_ack = 1'b1;
      bus.iv_rdata = 32'hA000_0000 + 32'(i);
      cyc();
      bus.i_rd_ack = 1'b0;
      bus.iv_rdata = '0;
      cyc();
      check_val($sformatf("ovf_resp%0d_wr", i), 66'(bus.o_resp_wr), 66'd1);
      check_val($sformatf("ovf_resp%0d", i), bus.ov_resp,
                {2'b11, 2'(i), 30'(32'h40 + i), 32'hA000_0000 + 32'(i)});
    end
    repeat (4) cyc();
    check_val("ovf_drained", 66'(bus.o_busy), 66'd0);
    check_val("ovf_drop_final", 66'(bus.ov_drop_cnt), 66'd1);

    // Illegal types 00 and 11: no strobes, two drops, then a normal write.
    seen = 1'b0;
    push(mk(2'b00, 2'b01, 30'h10, 32'h55));
    repeat (3) begin
      cyc();
      seen |= bus.o_wr | bus.o_rd | bus.o_resp_wr;
    end
    push(mk(2'b11, 2'b10, 30'h11, 32'h66));
    repeat (3) begin
      cyc();
      seen |= bus.o_wr | bus.o_rd | bus.o_resp_wr;
    end
    check_val("ill_no_strobe", 66'(seen), 66'd0);
    check_val("ill_drop", 66'(bus.ov_drop_cnt), 66'd3);
    push(mk(2'b01, 2'b00, 30'h200, 32'hA5A5_A5A5));
    cyc();
    cyc();
    check_val("ill_next_wr", 66'(bus.o_wr), 66'd1);
    check_val("ill_next_addr", 66'(bus.ov_addr), 66'h200);
    check_val("ill_next_wdata", 66'(bus.ov_wdata), 66'hA5A5_A5A5);

    // Reset while a read is outstanding with three more queued.
    push(mk(2'b10, 2'b10, 30'h30, 32'h0));
    cyc();
    cyc();
    check_val("rr_rd", 66'(bus.o_rd), 66'd1);
    for (int j = 0; j < 3; j++) push(mk(2'b10, 2'(j), 30'(32'h31 + j), 32'h0));
    check_val("rr_busy", 66'(bus.o_busy), 66'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rr_async");
    cyc();
    cyc();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (20) begin
      cyc();
      seen |= bus.o_resp_wr | bus.o_rd | bus.o_wr;
    end
    check_val("rr_no_activity", 66'(seen), 66'd0);
    check_val("rr_idle", 66'(bus.o_busy), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
